// File: rtl/cnn_layer_frame.sv
// One convolution layer over a raster-scanned frame: CO streaming cores,
// ReLU/shift/saturate post-processing, per-channel map buffers and a read port.

module cnn_core #(
  parameter I_F_BW = 8,
  parameter W_BW   = 7,
  parameter B_BW   = 7,
  parameter KX     = 5,
  parameter KY     = 5,
  parameter IX     = 28,
  parameter IY     = 28,
  parameter O_F_BW = 23
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pixel_valid,
  input  logic [I_F_BW-1:0]         pixel,
  input  logic [KX*KY*W_BW-1:0]     weight,
  input  logic [B_BW-1:0]           bias,
  output logic                      result_valid,
  output logic [O_F_BW-1:0]         result
);
  localparam int CW = $clog2(IX);
  localparam int RW = $clog2(IY);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              win_valid;
  logic [I_F_BW-1:0] lb  [KY-1][IX];
  logic [I_F_BW-1:0] win [KY][KX];
  logic signed [O_F_BW-1:0] acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      win_valid    <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      win_valid    <= 1'b0;
      result_valid <= win_valid;
      if (win_valid) result <= acc;
      if (pixel_valid) begin
        win_valid <= (col >= CW'(KX-1)) && (row >= RW'(KY-1));
        if (col == CW'(IX-1)) begin
          col <= '0;
          row <= (row == RW'(IY-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // lb[0] holds the oldest buffered row; win[r][c] = pixel(row-(KY-1)+r, col-(KX-1)+c)
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      for (int unsigned k = 0; k + 2 < KY; k++) lb[k][col] <= lb[k+1][col];
      lb[KY-2][col] <= pixel;
      for (int unsigned r = 0; r < KY; r++)
        for (int unsigned c = 0; c + 1 < KX; c++) win[r][c] <= win[r][c+1];
      for (int unsigned r = 0; r + 1 < KY; r++) win[r][KX-1] <= lb[r][col];
      win[KY-1][KX-1] <= pixel;
    end
  end

  always_comb begin
    acc = O_F_BW'($signed(bias));
    for (int unsigned r = 0; r < KY; r++)
      for (int unsigned c = 0; c < KX; c++)
        acc = acc + O_F_BW'($signed({1'b0, win[r][c]}) *
                            $signed(weight[(r*KX+c)*W_BW +: W_BW]));
  end
endmodule

module cnn_layer_frame #(
  parameter I_F_BW = 8,
  parameter W_BW   = 7,
  parameter B_BW   = 7,
  parameter KX     = 5,
  parameter KY     = 5,
  parameter CI     = 1,
  parameter CO     = 3,
  parameter IX     = 28,
  parameter IY     = 28,
  parameter OUT_W  = IX - KX + 1,
  parameter OUT_H  = IY - KY + 1,
  parameter O_F_BW = 23,
  parameter O_BW   = 8,
  parameter SHIFT  = 7,
  parameter AW     = $clog2(OUT_W*OUT_H),
  parameter CH_W   = (CO > 1) ? $clog2(CO) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_start,
  input  logic                         i_relu_en,
  input  logic                         i_valid,
  input  logic [I_F_BW-1:0]            i_pixel,
  input  logic [CO*CI*KX*KY*W_BW-1:0]  i_cnn_weight,
  input  logic [CO*B_BW-1:0]           i_cnn_bias,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_frame_ready,
  output logic                         o_overrun,
  output logic                         o_core_err,
  input  logic                         i_rd_en,
  input  logic [CH_W-1:0]              i_rd_ch,
  input  logic [AW-1:0]                i_rd_addr,
  output logic                         o_rd_valid,
  output logic [O_BW-1:0]              o_rd_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int NPIX = IX * IY;
  localparam int NOUT = OUT_W * OUT_H;
  localparam int IN_W = $clog2(NPIX + 1);
  localparam int XW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic signed [O_F_BW-1:0] SAT_MAX = O_F_BW'(2**(O_BW-1) - 1);
  localparam logic signed [O_F_BW-1:0] SAT_MIN = O_F_BW'(-(2**(O_BW-1)));

  logic [1:0]        state;
  logic [IN_W-1:0]   in_cnt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              relu_q;
  logic [CO-1:0]     cv;
  logic [O_F_BW-1:0] cd [CO];
  logic [O_BW-1:0]   bank [CO][NOUT];
  logic              core_in, start_ok, wr_en, last_wr;
  logic [AW-1:0]     wr_addr;

  assign o_busy   = (state == RUN);
  assign start_ok = i_start && (state != RUN);
  assign core_in  = (state == RUN) && i_valid && (in_cnt < IN_W'(NPIX));
  assign wr_en    = (state == RUN) && (&cv);
  assign last_wr  = wr_en && (x == XW'(OUT_W-1)) && (y == YW'(OUT_H-1));
  assign wr_addr  = AW'(y) * AW'(OUT_W) + AW'(x);

  for (genvar co = 0; co < CO; co++) begin : g_core
    cnn_core #(
      .I_F_BW(I_F_BW), .W_BW(W_BW), .B_BW(B_BW), .KX(KX), .KY(KY),
      .IX(IX), .IY(IY), .O_F_BW(O_F_BW)
    ) u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .pixel_valid  (core_in),
      .pixel        (i_pixel),
      .weight       (i_cnn_weight[co*CI*KX*KY*W_BW +: KX*KY*W_BW]),
      .bias         (i_cnn_bias[co*B_BW +: B_BW]),
      .result_valid (cv[co]),
      .result       (cd[co])
    );
  end

  function automatic logic [O_BW-1:0] post(input logic signed [O_F_BW-1:0] raw,
                                           input logic relu);
    logic signed [O_F_BW-1:0] v;
    v = (relu && raw < 0) ? '0 : raw;
    v = v >>> SHIFT;
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[O_BW-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_cnt        <= '0;
      x             <= '0;
      y             <= '0;
      relu_q        <= 1'b0;
      o_done        <= 1'b0;
      o_frame_ready <= 1'b0;
      o_overrun     <= 1'b0;
      o_core_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (start_ok) begin
        state         <= RUN;
        in_cnt        <= '0;
        x             <= '0;
        y             <= '0;
        relu_q        <= i_relu_en;
        o_frame_ready <= 1'b0;
        o_overrun     <= 1'b0;
        o_core_err    <= 1'b0;
      end else if (state == RUN) begin
        if (core_in) in_cnt <= in_cnt + 1'b1;
        if (i_valid && in_cnt == IN_W'(NPIX)) o_overrun <= 1'b1;
        if ((|cv) && !(&cv)) o_core_err <= 1'b1;
        if (wr_en) begin
          if (x == XW'(OUT_W-1)) begin
            x <= '0;
            y <= (y == YW'(OUT_H-1)) ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        if (last_wr) begin
          state         <= DONE;
          o_done        <= 1'b1;
          o_frame_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int unsigned ch = 0; ch < CO; ch++) bank[ch][wr_addr] <= post(cd[ch], relu_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        if (({1'b0, i_rd_ch} < (CH_W+1)'(CO)) && ({1'b0, i_rd_addr} < (AW+1)'(NOUT)))
          o_rd_data <= bank[i_rd_ch][i_rd_addr];
        else
          o_rd_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cnn_layer_frame.sv
// Bench for cnn_layer_frame: two instances (SHIFT=0 and SHIFT=7) share stimulus and
// are checked against a direct sliding-window convolution model of each frame.

module tb_cnn_layer_frame;
  localparam int IX = 28, IY = 28, KX = 5, KY = 5, CO = 3;
  localparam int OW = IX - KX + 1, OH = IY - KY + 1;
  localparam int NPIX = IX * IY, NOUT = OW * OH, NK = KX * KY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, i_start, i_relu_en, i_valid, i_rd_en;
  logic [7:0]           i_pixel;
  logic [CO*NK*7-1:0]   i_cnn_weight;
  logic [CO*7-1:0]      i_cnn_bias;
  logic [1:0]           i_rd_ch;
  logic [9:0]           i_rd_addr;
  logic busy0, done0, fr0, ovr0, cerr0, rdv0;
  logic busy7, done7, fr7, ovr7, cerr7, rdv7;
  logic [7:0] rdd0, rdd7;

  cnn_layer_frame #(.SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_relu_en(i_relu_en),
    .i_valid(i_valid), .i_pixel(i_pixel), .i_cnn_weight(i_cnn_weight),
    .i_cnn_bias(i_cnn_bias), .o_busy(busy0), .o_done(done0), .o_frame_ready(fr0),
    .o_overrun(ovr0), .o_core_err(cerr0), .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch),
    .i_rd_addr(i_rd_addr), .o_rd_valid(rdv0), .o_rd_data(rdd0));

  cnn_layer_frame #(.SHIFT(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_relu_en(i_relu_en),
    .i_valid(i_valid), .i_pixel(i_pixel), .i_cnn_weight(i_cnn_weight),
    .i_cnn_bias(i_cnn_bias), .o_busy(busy7), .o_done(done7), .o_frame_ready(fr7),
    .o_overrun(ovr7), .o_core_err(cerr7), .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch),
    .i_rd_addr(i_rd_addr), .o_rd_valid(rdv7), .o_rd_data(rdd7));

  int img [NPIX];
  int wts [CO][NK];
  int bias [CO];
  int exp0 [CO][NOUT];
  int exp7 [CO][NOUT];
  int passes = 0, total = 0;
  int done0_cnt = 0, done7_cnt = 0;

  always @(posedge clk) begin
    if (done0 === 1'b1) done0_cnt <= done0_cnt + 1;
    if (done7 === 1'b1) done7_cnt <= done7_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int post(input int raw, input bit relu, input int sh);
    int v;
    v = (relu && raw < 0) ? 0 : raw;
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic compute(input bit relu);
    int raw;
    for (int ch = 0; ch < CO; ch++)
      for (int yy = 0; yy < OH; yy++)
        for (int xx = 0; xx < OW; xx++) begin
          raw = bias[ch];
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
              raw += img[(yy+ky)*IX + xx + kx] * wts[ch][ky*KX + kx];
          exp0[ch][yy*OW + xx] = post(raw, relu, 0);
          exp7[ch][yy*OW + xx] = post(raw, relu, 7);
        end
  endtask

  task automatic set_uniform(input int pix, input int w);
    for (int p = 0; p < NPIX; p++) img[p] = pix;
    for (int ch = 0; ch < CO; ch++) begin
      bias[ch] = 0;
      for (int k = 0; k < NK; k++) wts[ch][k] = w;
    end
  endtask

  task automatic set_random();
    for (int p = 0; p < NPIX; p++) img[p] = int'($urandom_range(0, 255));
    for (int ch = 0; ch < CO; ch++) begin
      bias[ch] = int'($urandom_range(0, 127)) - 64;
      for (int k = 0; k < NK; k++) wts[ch][k] = int'($urandom_range(0, 127)) - 64;
    end
  endtask

  task automatic load_params();
    for (int ch = 0; ch < CO; ch++) begin
      i_cnn_bias[ch*7 +: 7] = 7'(bias[ch]);
      for (int k = 0; k < NK; k++) i_cnn_weight[(ch*NK + k)*7 +: 7] = 7'(wts[ch][k]);
    end
  endtask

  task automatic send_pixels(input int npix);
    for (int p = 0; p < npix; p++) begin
      i_valid   = 1'b1;
      i_pixel   = (p < NPIX) ? 8'(img[p]) : 8'($urandom);
      i_relu_en = 1'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input int npix, input bit relu, input bit stray);
    int b0, b7, t;
    load_params();
    compute(relu);
    @(negedge clk);
    i_start   = 1'b1;
    i_relu_en = relu;
    i_valid   = stray;
    i_pixel   = 8'($urandom);
    b0 = done0_cnt;
    b7 = done7_cnt;
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b0;
    chk("busy_after_start", 32'(busy0), 1);
    chk("busy7_after_start", 32'(busy7), 1);
    chk("overrun_cleared", 32'(ovr0), 0);
    chk("frame_ready_cleared", 32'(fr0), 0);
    send_pixels(npix);
    t = 0;
    while (done0_cnt == b0 && done0 !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("done_within_bound", 32'(t < 60), 1);
    if (done0 === 1'b1) begin
      chk("busy_low_with_done", 32'(busy0), 0);
      chk("ready_with_done", 32'(fr0), 1);
      chk("done7_lockstep", 32'(done7), 1);
    end
    repeat (3) @(negedge clk);
    chk("done_pulse_count", 32'(done0_cnt - b0), 1);
    chk("done7_pulse_count", 32'(done7_cnt - b7), 1);
    chk("frame_ready", 32'(fr0), 1);
    chk("frame_ready7", 32'(fr7), 1);
    chk("busy_after_frame", 32'(busy0), 0);
    chk("overrun_flag", 32'(ovr0), 32'(npix > NPIX));
    chk("overrun7_flag", 32'(ovr7), 32'(npix > NPIX));
    chk("core_err", 32'(cerr0), 0);
  endtask

  task automatic read_map();
    int pc = 0, pa = 0;
    for (int i = 0; i <= CO*NOUT; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rd_valid", 32'(rdv0), 1);
        chk("map_shift0", 32'(rdd0), 32'(exp0[pc][pa] & 255));
        chk("map_shift7", 32'(rdd7), 32'(exp7[pc][pa] & 255));
      end
      if (i < CO*NOUT) begin
        pc = i / NOUT;
        pa = i % NOUT;
        i_rd_en   = 1'b1;
        i_rd_ch   = 2'(pc);
        i_rd_addr = 10'(pa);
      end else begin
        i_rd_en = 1'b0;
      end
    end
  endtask

  task automatic rd1(input string tag, input int ch, input int addr, input int e0, input int e7);
    @(negedge clk);
    i_rd_en   = 1'b1;
    i_rd_ch   = 2'(ch);
    i_rd_addr = 10'(addr);
    @(negedge clk);
    i_rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rdv0), 1);
    chk({tag, "_data0"}, 32'(rdd0), 32'(e0 & 255));
    chk({tag, "_data7"}, 32'(rdd7), 32'(e7 & 255));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(rdv0), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'({busy0, busy7}), 0);
    chk({tag, "_done"}, 32'({done0, done7}), 0);
    chk({tag, "_ready"}, 32'({fr0, fr7}), 0);
    chk({tag, "_overrun"}, 32'({ovr0, ovr7}), 0);
    chk({tag, "_core_err"}, 32'({cerr0, cerr7}), 0);
    chk({tag, "_rd_valid"}, 32'({rdv0, rdv7}), 0);
    chk({tag, "_rd_data"}, 32'({rdd0, rdd7}), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_relu_en = 1'b0; i_valid = 1'b0; i_pixel = '0;
    i_cnn_weight = '0; i_cnn_bias = '0; i_rd_en = 1'b0; i_rd_ch = '0; i_rd_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // all-ones kernel over a flat image, with a stray pixel in the start cycle
    set_uniform(1, 1);
    run_frame(NPIX, 1'b0, 1'b1);
    read_map();

    set_uniform(127, 63);
    run_frame(NPIX, 1'b0, 1'b0);
    read_map();

    set_uniform(1, -1);
    run_frame(NPIX, 1'b0, 1'b0);
    read_map();
    run_frame(NPIX, 1'b1, 1'b0);
    read_map();

    set_random();
    run_frame(NPIX + 5, 1'(($urandom)), 1'b1);
    read_map();

    set_random();
    run_frame(NPIX, 1'($urandom), 1'b0);
    read_map();
    rd1("rd_last", CO-1, NOUT-1, exp0[CO-1][NOUT-1], exp7[CO-1][NOUT-1]);
    rd1("rd_bad_ch", CO, 0, 0, 0);
    rd1("rd_bad_addr", 0, NOUT, 0, 0);

    // pixels offered in IDLE must leave the buffered map untouched
    pulse_reset();
    check_reset_outputs("reset_idle");
    for (int i = 0; i < 40; i++) begin
      i_valid = 1'b1;
      i_pixel = 8'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("idle_stays_idle", 32'({busy0, fr0}), 0);
    read_map();

    set_random();
    load_params();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    send_pixels(300);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_midframe");
    @(negedge clk);
    reset_n = 1'b1;

    set_random();
    run_frame(NPIX, 1'($urandom), 1'b0);
    read_map();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #5ms;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end
endmodule
